// File: rtl/cic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cic_pkg: width, clamp helpers and limits shared by the CIC decimator |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cic_pkg;

    localparam int CIC_MAX_ORDER = 5;

    function automatic int cic_width(input int order, input int dec_log2);
        return order * dec_log2 + 1;
    endfunction

    // Zero or oversized ratios fall back to the largest supported decimation.
    function automatic int clamp_dec(input int dec, input int max_dec);
        if (dec < 1 || dec > max_dec) begin
            return max_dec;
        end
        return dec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_integrator_chain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cic_integrator_chain: bitstream coder and pipelined integrator stack |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cic_integrator_chain #(
    parameter int ORDER   = 3,
    parameter int W       = 25,
    parameter int BIPOLAR = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         run,
    input  logic         in,
    output logic [W-1:0] acc_out
);

    logic [W-1:0] r_acc [ORDER];
    logic [W-1:0] w_code;

    always_comb begin
        if (in) begin
            w_code = W'(1);
        end else if (BIPOLAR != 0) begin
            w_code = '1;
        end else begin
            w_code = '0;
        end
    end

    // Each stage adds the previous stage's registered value; wrap-around is intended.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < ORDER; k++) begin
                r_acc[k] <= '0;
            end
        end else if (clear) begin
            for (int k = 0; k < ORDER; k++) begin
                r_acc[k] <= '0;
            end
        end else if (run) begin
            r_acc[0] <= r_acc[0] + w_code;
            for (int k = 1; k < ORDER; k++) begin
                r_acc[k] <= r_acc[k] + r_acc[k-1];
            end
        end
    end

    assign acc_out = r_acc[ORDER-1];

endmodule
`default_nettype wire

// File: rtl/cic_decim_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cic_decim_param: run-time selectable CIC decimator for 1-bit streams |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cic_decim_param
    import cic_pkg::*;
#(
    parameter int ORDER        = 3,
    parameter int MAX_DEC_LOG2 = 8,
    parameter int BIPOLAR      = 0,
    parameter int W            = cic_width(ORDER, MAX_DEC_LOG2)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in,
    input  logic                              en,
    input  logic [$clog2(MAX_DEC_LOG2+1)-1:0] dec_log2,
    output logic [W-1:0]                      out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              overrun
);

    localparam int c_DLW = $clog2(MAX_DEC_LOG2 + 1);
    localparam int c_CW  = MAX_DEC_LOG2;
    localparam int c_PW  = $clog2(CIC_MAX_ORDER + 1);

    logic             r_en_q;
    logic [c_DLW-1:0] r_dec_q;
    logic [c_CW-1:0]  r_cnt;
    logic [c_PW-1:0]  r_prime;
    logic [W-1:0]     r_comb_d [ORDER];
    logic [W-1:0]     r_res;
    logic             r_load;

    logic             w_start;
    logic             w_run;
    logic             w_tick;
    logic             w_primed;
    logic [c_CW-1:0]  w_mask;
    logic [W-1:0]     w_acc;
    logic [W-1:0]     w_diff [ORDER];
    logic [7:0]       w_shamt;
    logic [W-1:0]     w_scaled;

    assign w_start  = en & ~r_en_q;
    assign w_run    = en & r_en_q;
    assign w_mask   = c_CW'((32'd1 << r_dec_q) - 32'd1);
    assign w_tick   = w_run && (r_cnt == w_mask);
    assign w_primed = (r_prime == c_PW'(ORDER));
    assign w_shamt  = 8'(ORDER * (MAX_DEC_LOG2 - int'(r_dec_q)));
    assign w_scaled = w_diff[ORDER-1] << w_shamt;

    cic_integrator_chain #(
        .ORDER   (ORDER),
        .W       (W),
        .BIPOLAR (BIPOLAR)
    ) u_integrators (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_start),
        .run     (w_run),
        .in      (in),
        .acc_out (w_acc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en_q  <= 1'b0;
            r_dec_q <= '0;
            r_cnt   <= '0;
            r_prime <= '0;
        end else begin
            r_en_q <= en;
            if (w_start) begin
                r_dec_q <= c_DLW'(clamp_dec(int'(dec_log2), MAX_DEC_LOG2));
                r_cnt   <= '0;
                r_prime <= '0;
            end else if (w_run) begin
                r_cnt <= (r_cnt + 1'b1) & w_mask;
                if (w_tick && !w_primed) begin
                    r_prime <= r_prime + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_diff[0] = w_acc - r_comb_d[0];
        for (int k = 1; k < ORDER; k++) begin
            w_diff[k] = w_diff[k-1] - r_comb_d[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < ORDER; k++) begin
                r_comb_d[k] <= '0;
            end
        end else if (w_start) begin
            for (int k = 0; k < ORDER; k++) begin
                r_comb_d[k] <= '0;
            end
        end else if (w_tick) begin
            r_comb_d[0] <= w_acc;
            for (int k = 1; k < ORDER; k++) begin
                r_comb_d[k] <= w_diff[k-1];
            end
        end
    end

    // Scaled result is staged one cycle before it reaches the consumer-facing register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_load    <= 1'b0;
            r_res     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_load <= w_tick && w_primed;
            if (w_tick) begin
                r_res <= w_scaled;
            end
            if (w_start) begin
                out_valid <= 1'b0;
                overrun   <= 1'b0;
            end else if (r_load) begin
                out_data  <= r_res;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cic_decim_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cic_decim_param: scoreboard bench for unipolar and bipolar CICs   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cic_decim_param;

    localparam int W = 25;
    localparam logic [W-1:0] FS   = 25'h1000000;
    localparam logic [W-1:0] HALF = 25'h0800000;
    localparam logic [W-1:0] ZERO = 25'h0000000;

    logic         clk       = 1'b0;
    logic         reset_n   = 1'b0;
    logic         in        = 1'b0;
    logic         en        = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   dec_log2  = 4'd8;
    logic [W-1:0] data_u, data_b;
    logic         valid_u, valid_b, ovr_u, ovr_b;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] q_u[$];
    logic [W-1:0] q_b[$];

    always #5 clk = ~clk;

    cic_decim_param #(.ORDER(3), .MAX_DEC_LOG2(8), .BIPOLAR(0)) u_uni (
        .clk(clk), .reset_n(reset_n), .in(in), .en(en), .dec_log2(dec_log2),
        .out_data(data_u), .out_valid(valid_u), .out_ready(out_ready), .overrun(ovr_u)
    );

    cic_decim_param #(.ORDER(3), .MAX_DEC_LOG2(8), .BIPOLAR(1)) u_bi (
        .clk(clk), .reset_n(reset_n), .in(in), .en(en), .dec_log2(dec_log2),
        .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready), .overrun(ovr_b)
    );

    task automatic check_i(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic check_d(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pat_bit(input int pat, input int n);
        case (pat)
            0:       return 1'b0;
            1:       return 1'b1;
            default: return (n % 2) == 1;
        endcase
    endfunction

    // Monitors: every accepted transfer is matched against the scoreboard queues.
    always @(negedge clk) begin
        if (reset_n && valid_u && out_ready) begin
            if (q_u.size() == 0) check_i("uni spurious result", int'(valid_u), 0);
            else check_d("uni result", data_u, q_u.pop_front());
        end
    end

    always @(negedge clk) begin
        if (reset_n && valid_b && out_ready) begin
            if (q_b.size() == 0) check_i("bi spurious result", int'(valid_b), 0);
            else check_d("bi result", data_b, q_b.pop_front());
        end
    end

    task automatic run_frame(input string name, input logic [3:0] dec, input int pat,
                             input int nres, input logic [W-1:0] exp_u,
                             input logic [W-1:0] exp_b, input int exp_d,
                             input logic [3:0] dec_late);
        int n;
        int first;
        int budget;
        n      = 0;
        first  = -1;
        budget = (nres + 6) * exp_d + 20;
        en = 1'b0;
        step();
        dec_log2 = dec;
        in       = pat_bit(pat, 0);
        en       = 1'b1;
        step();
        dec_log2 = dec_late;
        for (int i = 0; i < nres; i++) begin
            q_u.push_back(exp_u);
            q_b.push_back(exp_b);
        end
        while ((q_u.size() != 0 || q_b.size() != 0) && n < budget) begin
            in = pat_bit(pat, n + 1);
            step();
            n++;
            if (first < 0 && valid_u) first = n;
        end
        check_i({name, " first-valid latency"}, first, 4 * exp_d + 1);
        check_i({name, " results drained"}, q_u.size() + q_b.size(), 0);
        check_i({name, " no overrun"}, int'(ovr_u) + int'(ovr_b), 0);
        q_u.delete();
        q_b.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int n;
        int saw;
        repeat (3) step();
        check_d("reset out_data", data_u, ZERO);
        check_i("reset out_valid", int'(valid_u) + int'(valid_b), 0);
        check_i("reset overrun", int'(ovr_u) + int'(ovr_b), 0);
        reset_n = 1'b1;
        step();

        run_frame("dec8 ones", 4'd8, 1, 3, FS, FS, 256, 4'd8);
        run_frame("dec4 ones", 4'd4, 1, 4, FS, FS, 16, 4'd4);
        run_frame("dec4 zeros", 4'd4, 0, 3, ZERO, FS, 16, 4'd4);
        run_frame("dec8 alternating", 4'd8, 2, 2, HALF, ZERO, 256, 4'd8);
        run_frame("dec0 clamps to 8", 4'd0, 1, 1, FS, FS, 256, 4'd0);
        run_frame("dec change ignored", 4'd4, 1, 2, FS, FS, 16, 4'd2);

        // Overrun: two loads without a ready consumer.
        en = 1'b0;
        step();
        dec_log2 = 4'd4; in = 1'b1; out_ready = 1'b0; en = 1'b1;
        step();
        n = 0;
        while (!valid_u && n < 200) begin step(); n++; end
        check_i("ovr first valid", n, 65);
        check_i("ovr clear before second load", int'(ovr_u), 0);
        repeat (16) step();
        check_i("ovr set uni", int'(ovr_u), 1);
        check_i("ovr set bi", int'(ovr_b), 1);
        check_i("ovr valid held", int'(valid_u), 1);
        check_d("ovr data is second result", data_u, FS);
        q_u.push_back(FS); q_b.push_back(FS);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_i("ovr valid cleared after read", int'(valid_u), 0);
        check_i("ovr sticky after read", int'(ovr_u), 1);
        check_i("ovr read drained", q_u.size() + q_b.size(), 0);
        q_u.push_back(FS); q_b.push_back(FS);
        out_ready = 1'b1;
        n = 0;
        while ((q_u.size() != 0 || q_b.size() != 0) && n < 40) begin step(); n++; end
        check_i("ovr next result drained", q_u.size() + q_b.size(), 0);
        check_i("ovr sticky after later result", int'(ovr_u), 1);
        q_u.delete(); q_b.delete();
        en = 1'b0;
        step();

        // en low mid-frame, then restart.
        dec_log2 = 4'd4; in = 1'b1; en = 1'b1;
        step();
        check_i("start clears overrun", int'(ovr_u), 0);
        repeat (40) step();
        en = 1'b0;
        saw = 0;
        repeat (100) begin step(); if (valid_u || valid_b) saw = 1; end
        check_i("no result while en low", saw, 0);
        run_frame("restart after en low", 4'd4, 1, 2, FS, FS, 16, 4'd4);

        // Asynchronous reset with a pending result and overrun.
        en = 1'b0;
        step();
        dec_log2 = 4'd4; in = 1'b1; out_ready = 1'b0; en = 1'b1;
        step();
        repeat (81) step();
        check_i("pre-reset valid", int'(valid_u), 1);
        check_i("pre-reset overrun", int'(ovr_u), 1);
        #2;
        reset_n = 1'b0;
        en      = 1'b0;
        #1;
        check_i("async reset out_valid", int'(valid_u) + int'(valid_b), 0);
        check_d("async reset out_data", data_u, ZERO);
        check_i("async reset overrun", int'(ovr_u) + int'(ovr_b), 0);
        step();
        step();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        saw = 0;
        repeat (30) begin step(); if (valid_u || valid_b) saw = 1; end
        check_i("idle after reset", saw, 0);
        run_frame("frame after reset", 4'd4, 1, 2, FS, FS, 16, 4'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
